// File: rtl/clock_alarm_engine.sv
// Timekeeping core (prescaler -> s -> min -> h) with BCD digits and NUM_ALARMS ringing/snooze channels.
// Optional 12-hour digit display and pm flag: define TWELVE_HOUR_EN.
module clock_alarm_engine #(
    parameter  int TICK_COUNT_MAX = 50000000,
    parameter  int NUM_ALARMS     = 2,
    parameter  int SNOOZE_MIN     = 5,
    parameter  int RING_MIN       = 3,
    localparam int IW             = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_valid,
    input  logic [4:0]            set_hours,
    input  logic [5:0]            set_minutes,
    input  logic                  alarm_wr,
    input  logic [IW-1:0]         alarm_idx,
    input  logic [4:0]            alarm_hours,
    input  logic [5:0]            alarm_minutes,
    input  logic                  alarm_en,
    input  logic                  alarm_stop,
    input  logic                  alarm_snooze,
    output logic [5:0]            seconds,
    output logic [5:0]            minutes,
    output logic [4:0]            hours,
    output logic [3:0]            min_unit,
    output logic [3:0]            min_ten,
    output logic [3:0]            hour_unit,
    output logic [3:0]            hour_ten,
    output logic                  pm,
    output logic                  cfg_err,
    output logic [NUM_ALARMS-1:0] alarm_ringing,
    output logic                  alarm_trigger
);

    localparam int PW = $clog2(TICK_COUNT_MAX);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} ch_state_t;

    function automatic logic [3:0] bcd_unit(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    function automatic logic [3:0] bcd_ten(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    // Value shown on the hour digits; the hours counter itself stays 24-hour.
    function automatic logic [5:0] hour_disp(input logic [4:0] h);
`ifdef TWELVE_HOUR_EN
        if (h == 5'd0)
            return 6'd12;
        else if (h > 5'd12)
            return {1'b0, h - 5'd12};
        else
            return {1'b0, h};
`else
        return {1'b0, h};
`endif
    endfunction

    logic [PW-1:0] presc_q, presc_nx;
    logic [5:0]    sec_nx, min_nx;
    logic [4:0]    hr_nx;
    logic          strobe_nx, min_strobe, pm_nx;
    logic          tick, set_ok, wr_ok;
    logic [5:0]    hr_shown;

    assign tick   = (presc_q == PW'(TICK_COUNT_MAX - 1));
    assign set_ok = set_valid && (set_hours < 5'd24) && (set_minutes < 6'd60);
    assign wr_ok  = alarm_wr && (32'(alarm_idx) < 32'(NUM_ALARMS))
                    && (alarm_hours < 5'd24) && (alarm_minutes < 6'd60);

    // A valid set overrides the tick on the same edge and restarts the second.
    always_comb begin
        presc_nx  = presc_q;
        sec_nx    = seconds;
        min_nx    = minutes;
        hr_nx     = hours;
        strobe_nx = 1'b0;
        if (set_ok) begin
            presc_nx = '0;
            sec_nx   = '0;
            min_nx   = set_minutes;
            hr_nx    = set_hours;
        end else if (tick) begin
            presc_nx = '0;
            if (seconds == 6'd59) begin
                sec_nx    = '0;
                strobe_nx = 1'b1;
                if (minutes == 6'd59) begin
                    min_nx = '0;
                    hr_nx  = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                end else begin
                    min_nx = minutes + 6'd1;
                end
            end else begin
                sec_nx = seconds + 6'd1;
            end
        end else begin
            presc_nx = presc_q + PW'(1);
        end
    end

    assign hr_shown = hour_disp(hr_nx);
`ifdef TWELVE_HOUR_EN
    assign pm_nx = (hr_nx >= 5'd12);
`else
    assign pm_nx = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            seconds    <= '0;
            minutes    <= '0;
            hours      <= '0;
            min_unit   <= '0;
            min_ten    <= '0;
            hour_unit  <= '0;
            hour_ten   <= '0;
            pm         <= 1'b0;
            cfg_err    <= 1'b0;
            min_strobe <= 1'b0;
        end else begin
            presc_q    <= presc_nx;
            seconds    <= sec_nx;
            minutes    <= min_nx;
            hours      <= hr_nx;
            min_unit   <= bcd_unit(min_nx);
            min_ten    <= bcd_ten(min_nx);
            hour_unit  <= bcd_unit(hr_shown);
            hour_ten   <= bcd_ten(hr_shown);
            pm         <= pm_nx;
            cfg_err    <= (set_valid && !set_ok) || (alarm_wr && !wr_ok);
            min_strobe <= strobe_nx;
        end
    end

    ch_state_t             state_q [NUM_ALARMS];
    ch_state_t             state_d [NUM_ALARMS];
    logic [5:0]            ring_q  [NUM_ALARMS];
    logic [5:0]            ring_d  [NUM_ALARMS];
    logic [5:0]            snz_q   [NUM_ALARMS];
    logic [5:0]            snz_d   [NUM_ALARMS];
    logic                  en_q    [NUM_ALARMS];
    logic [4:0]            ahr_q   [NUM_ALARMS];
    logic [5:0]            amin_q  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] wr_hit;

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            if (wr_ok && (alarm_idx == IW'(i)))
                wr_hit[i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (rst) begin
                en_q[i]   <= 1'b0;
                ahr_q[i]  <= '0;
                amin_q[i] <= '0;
            end else if (wr_hit[i]) begin
                en_q[i]   <= alarm_en;
                ahr_q[i]  <= alarm_hours;
                amin_q[i] <= alarm_minutes;
            end
        end
    end

    // Any accepted write to a channel parks it in IDLE, which also covers disabling it mid-ring.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_d[i] = state_q[i];
            ring_d[i]  = ring_q[i];
            snz_d[i]   = snz_q[i];
            if (wr_hit[i]) begin
                state_d[i] = IDLE;
                ring_d[i]  = '0;
                snz_d[i]   = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (min_strobe && en_q[i] && (hours == ahr_q[i]) && (minutes == amin_q[i])) begin
                            state_d[i] = RINGING;
                            ring_d[i]  = '0;
                        end
                    end
                    RINGING: begin
                        if (alarm_stop) begin
                            state_d[i] = IDLE;
                        end else if (alarm_snooze) begin
                            state_d[i] = SNOOZED;
                            snz_d[i]   = 6'(SNOOZE_MIN);
                        end else if (min_strobe) begin
                            if (ring_q[i] + 6'd1 >= 6'(RING_MIN))
                                state_d[i] = IDLE;
                            else
                                ring_d[i] = ring_q[i] + 6'd1;
                        end
                    end
                    SNOOZED: begin
                        if (alarm_stop) begin
                            state_d[i] = IDLE;
                        end else if (min_strobe) begin
                            snz_d[i] = snz_q[i] - 6'd1;
                            if (snz_q[i] == 6'd1) begin
                                state_d[i] = RINGING;
                                ring_d[i]  = '0;
                            end
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (rst) begin
                state_q[i]       <= IDLE;
                ring_q[i]        <= '0;
                snz_q[i]         <= '0;
                alarm_ringing[i] <= 1'b0;
            end else begin
                state_q[i]       <= state_d[i];
                ring_q[i]        <= ring_d[i];
                snz_q[i]         <= snz_d[i];
                alarm_ringing[i] <= (state_d[i] == RINGING);
            end
        end
    end

    assign alarm_trigger = |alarm_ringing;

endmodule

// File: tb/tb_clock_alarm_engine.sv
// Directed bench for clock_alarm_engine with a queue scoreboard (TICK_COUNT_MAX=4, so one minute = 240 cycles).
// Hour-digit expectations follow TWELVE_HOUR_EN when it is defined.
module tb_clock_alarm_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_valid = 1'b0;
    logic [4:0] set_hours = '0;
    logic [5:0] set_minutes = '0;
    logic       alarm_wr = 1'b0;
    logic [0:0] alarm_idx = '0;
    logic [4:0] alarm_hours = '0;
    logic [5:0] alarm_minutes = '0;
    logic       alarm_en = 1'b0;
    logic       alarm_stop = 1'b0;
    logic       alarm_snooze = 1'b0;
    logic [5:0] seconds, minutes;
    logic [4:0] hours;
    logic [3:0] min_unit, min_ten, hour_unit, hour_ten;
    logic       pm, cfg_err, alarm_trigger;
    logic [1:0] alarm_ringing;

    clock_alarm_engine #(
        .TICK_COUNT_MAX(4), .NUM_ALARMS(2), .SNOOZE_MIN(5), .RING_MIN(3)
    ) dut (
        .clk(clk), .rst(rst),
        .set_valid(set_valid), .set_hours(set_hours), .set_minutes(set_minutes),
        .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes), .alarm_en(alarm_en),
        .alarm_stop(alarm_stop), .alarm_snooze(alarm_snooze),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .min_unit(min_unit), .min_ten(min_ten), .hour_unit(hour_unit), .hour_ten(hour_ten),
        .pm(pm), .cfg_err(cfg_err), .alarm_ringing(alarm_ringing), .alarm_trigger(alarm_trigger)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    task automatic push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = 32'(v);
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed=%0d expected=<none>", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val)
            else begin
                bad++;
                $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic int disp_hr(input int h);
`ifdef TWELVE_HOUR_EN
        return (h % 12 == 0) ? 12 : h % 12;
`else
        return h;
`endif
    endfunction

    function automatic int exp_pm(input int h);
`ifdef TWELVE_HOUR_EN
        return (h >= 12) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic push_hr_digits(input int h);
        push("hour_unit", disp_hr(h) % 10);
        push("hour_ten", disp_hr(h) / 10);
        push("pm", exp_pm(h));
    endtask

    task automatic chk_hr_digits();
        chk(32'(hour_unit));
        chk(32'(hour_ten));
        chk(32'(pm));
    endtask

    task automatic push_ring(input int r);
        push("alarm_ringing", r);
        push("alarm_trigger", (r != 0) ? 1 : 0);
    endtask

    task automatic chk_ring();
        chk(32'(alarm_ringing));
        chk(32'(alarm_trigger));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_set(input int h, input int m);
        set_valid   = 1'b1;
        set_hours   = 5'(h);
        set_minutes = 6'(m);
    endtask

    task automatic do_alarm(input int idx, input int h, input int m, input logic en);
        alarm_wr      = 1'b1;
        alarm_idx     = 1'(idx);
        alarm_hours   = 5'(h);
        alarm_minutes = 6'(m);
        alarm_en      = en;
    endtask

    task automatic pulse();
        cyc(1);
        set_valid    = 1'b0;
        alarm_wr     = 1'b0;
        alarm_stop   = 1'b0;
        alarm_snooze = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        cyc(3);
        push("seconds", 0); push("minutes", 0); push("hours", 0);
        push("min_unit", 0); push("min_ten", 0); push("hour_unit", 0); push("hour_ten", 0);
        push("pm", 0); push("cfg_err", 0); push_ring(0);
        chk(32'(seconds)); chk(32'(minutes)); chk(32'(hours));
        chk(32'(min_unit)); chk(32'(min_ten)); chk(32'(hour_unit)); chk(32'(hour_ten));
        chk(32'(pm)); chk(32'(cfg_err)); chk_ring();

        // free run from reset release: first minute completes on edge 240
        rst = 1'b0;
        cyc(236);
        push("seconds_236", 59); push("minutes_236", 0);
        chk(32'(seconds)); chk(32'(minutes));
        cyc(3);
        push("seconds_239", 59);
        chk(32'(seconds));
        cyc(1);
        push("minutes_240", 1); push("seconds_240", 0); push("min_unit_240", 1); push("min_ten_240", 0);
        push_hr_digits(0);
        chk(32'(minutes)); chk(32'(seconds)); chk(32'(min_unit)); chk(32'(min_ten));
        chk_hr_digits();

        // set 23:59 and roll over midnight
        do_set(23, 59);
        pulse();
        push("set_hours", 23); push("set_minutes", 59); push("set_seconds", 0);
        push("set_min_ten", 5); push_hr_digits(23);
        chk(32'(hours)); chk(32'(minutes)); chk(32'(seconds)); chk(32'(min_ten)); chk_hr_digits();
        cyc(240);
        push("midnight_h", 0); push("midnight_m", 0); push("midnight_s", 0); push_hr_digits(0);
        chk(32'(hours)); chk(32'(minutes)); chk(32'(seconds)); chk_hr_digits();

        // invalid sets
        do_set(24, 0);
        pulse();
        push("cfg_err_h24", 1); push("h_after_bad", 0); push("m_after_bad", 0);
        chk(32'(cfg_err)); chk(32'(hours)); chk(32'(minutes));
        cyc(1);
        push("cfg_err_clear", 0);
        chk(32'(cfg_err));
        do_set(5, 60);
        pulse();
        push("cfg_err_m60", 1); push("h_after_bad2", 0);
        chk(32'(cfg_err)); chk(32'(hours));

        // set on the same edge as a prescaler wrap: set wins, second restarts
        do_set(10, 0);
        pulse();
        cyc(3);
        do_set(10, 30);
        pulse();
        push("setwin_s", 0); push("setwin_m", 30); push_hr_digits(10);
        chk(32'(seconds)); chk(32'(minutes)); chk_hr_digits();
        cyc(3);
        push("setwin_s3", 0);
        chk(32'(seconds));
        cyc(1);
        push("setwin_s4", 1);
        chk(32'(seconds));

        // alarm 0 at 07:00 rings on rollover then auto-offs after RING_MIN minutes
        do_alarm(0, 7, 0, 1'b1);
        pulse();
        push("alarm_wr_ok", 0);
        chk(32'(cfg_err));
        do_set(6, 59);
        pulse();
        cyc(240);
        push("h_0700", 7); push("m_0700", 0); push_ring(0);
        chk(32'(hours)); chk(32'(minutes)); chk_ring();
        cyc(1);
        push_ring(1);
        chk_ring();
        cyc(719);
        push_ring(1);
        chk_ring();
        cyc(1);
        push_ring(0);
        chk_ring();

        // snooze, re-ring after SNOOZE_MIN, then stop; set and alarm write share a cycle
        do_set(7, 4);
        do_alarm(0, 7, 5, 1'b1);
        pulse();
        push("both_cfg_err", 0); push("both_min", 4);
        chk(32'(cfg_err)); chk(32'(minutes));
        cyc(240);
        push_ring(0);
        chk_ring();
        cyc(1);
        push_ring(1);
        chk_ring();
        alarm_snooze = 1'b1;
        pulse();
        push_ring(0);
        chk_ring();
        cyc(1198);
        push_ring(0);
        chk_ring();
        cyc(1);
        push_ring(1);
        chk_ring();
        alarm_stop = 1'b1;
        pulse();
        push_ring(0);
        chk_ring();

        // stop and snooze together go to IDLE, not SNOOZED
        do_set(7, 19);
        do_alarm(0, 7, 20, 1'b1);
        pulse();
        cyc(241);
        push_ring(1);
        chk_ring();
        alarm_stop   = 1'b1;
        alarm_snooze = 1'b1;
        pulse();
        push_ring(0);
        chk_ring();
        cyc(1200);
        push_ring(0);
        chk_ring();

        // loading a time equal to the alarm time does not fire
        do_set(8, 0);
        do_alarm(0, 8, 0, 1'b1);
        pulse();
        cyc(3);
        push_ring(0);
        chk_ring();

        // two channels, disable one mid-ring, rejected writes leave channels alone
        do_alarm(0, 8, 30, 1'b1);
        pulse();
        do_set(8, 29);
        do_alarm(1, 8, 30, 1'b1);
        pulse();
        cyc(240);
        push_ring(0);
        chk_ring();
        cyc(1);
        push_ring(3);
        chk_ring();
        do_alarm(1, 8, 30, 1'b0);
        pulse();
        push_ring(1);
        chk_ring();
        do_alarm(1, 24, 0, 1'b1);
        pulse();
        push("bad_alarm_h", 1); push_ring(1);
        chk(32'(cfg_err)); chk_ring();
        do_alarm(0, 8, 60, 1'b1);
        pulse();
        push("bad_alarm_m", 1); push_ring(1);
        chk(32'(cfg_err)); chk_ring();
        alarm_stop = 1'b1;
        pulse();
        push_ring(0);
        chk_ring();

        // hour digit display
        do_set(0, 15);
        pulse();
        push_hr_digits(0);
        chk_hr_digits();
        do_set(13, 5);
        pulse();
        push_hr_digits(13); push("min_unit_05", 5); push("min_ten_05", 0);
        chk_hr_digits(); chk(32'(min_unit)); chk(32'(min_ten));

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: observed=%0d expected=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
